// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage holding the PC, instruction memory and IF/ID register
module fetch_stage #(
  parameter int          IM_DEPTH = 128,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] PC,
  output logic [31:0] FD_PC,
  output logic [31:0] FD_IR,
  output logic        fd_valid,
  output logic        imem_fault,
  output logic [31:0] fetch_count
);
  localparam int AW = IM_DEPTH > 1 ? $clog2(IM_DEPTH) : 1;
  logic [31:0] instruction [IM_DEPTH];
  logic [31:0] r_pc, r_fd_pc, r_fd_ir, r_cnt;
  logic        r_valid, r_fault;
  logic [31:0] w_pc4, w_fword, w_next_pc;
  logic [AW-1:0] w_idx;
  logic        w_fault, w_load;
  assign w_pc4     = r_pc + 32'd4;
  assign w_fault   = (r_pc[31:2] >= 30'(IM_DEPTH)) || (r_pc[1:0] != 2'b00);
  assign w_idx     = r_pc[AW+1:2];
  assign w_fword   = w_fault ? NOP_WORD : instruction[w_idx];
  assign w_load    = !flush && !stall;
  assign w_next_pc = branch_taken ? branch_target : jump ? jump_target : stall ? r_pc : w_pc4;
  // PC register: redirects win over stall, otherwise advance by one word
  always_ff @(posedge clk or posedge rst)
    if (rst) r_pc <= RESET_PC;
    else     r_pc <= w_next_pc;
  // IF/ID register: flush injects a bubble, stall holds, otherwise capture the fetch
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_fd_ir <= NOP_WORD;
      r_fd_pc <= 32'd0;
      r_valid <= 1'b0;
    end else if (flush) begin
      r_fd_ir <= NOP_WORD;
      r_fd_pc <= 32'd0;
      r_valid <= 1'b0;
    end else if (!stall) begin
      r_fd_ir <= w_fword;
      r_fd_pc <= w_pc4;
      r_valid <= !w_fault;
    end
  // Sticky fault flag and count of real instructions entering IF/ID
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_fault <= 1'b0;
      r_cnt   <= 32'd0;
    end else if (w_load) begin
      r_fault <= r_fault | w_fault;
      r_cnt   <= r_cnt + {31'd0, !w_fault};
    end
  assign PC          = r_pc;
  assign FD_PC       = r_fd_pc;
  assign FD_IR       = r_fd_ir;
  assign fd_valid    = r_valid;
  assign imem_fault  = r_fault;
  assign fetch_count = r_cnt;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for the fetch stage
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0020;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, flush = 1'b0, branch_taken = 1'b0, jump = 1'b0;
  logic [31:0] branch_target = '0, jump_target = '0;
  logic [31:0] PC, FD_PC, FD_IR, fetch_count;
  logic fd_valid, imem_fault;
  int checks = 0, errors = 0;
  typedef struct {
    logic [31:0] pc, fdpc, fdir, cnt;
    logic        valid, fault;
  } exp_t;
  exp_t q[$];
  logic [31:0] mem [128];
  logic [31:0] m_pc, m_fdpc, m_fdir, m_cnt;
  logic        m_valid, m_fault;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .PC(PC), .FD_PC(FD_PC), .FD_IR(FD_IR), .fd_valid(fd_valid),
    .imem_fault(imem_fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_fdpc = 32'd0; m_fdir = NOP; m_cnt = 32'd0; m_valid = 1'b0; m_fault = 1'b0;
  endtask

  task automatic step(input logic s, input logic f, input logic b, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt);
    logic        flt;
    logic [31:0] fw;
    exp_t        e, o;
    stall = s; flush = f; branch_taken = b; branch_target = bt; jump = j; jump_target = jt;
    flt = (m_pc[31:2] >= 30'd128) || (m_pc[1:0] != 2'b00);
    fw  = flt ? NOP : mem[m_pc[8:2]];
    if (f) begin
      m_fdir = NOP; m_fdpc = 32'd0; m_valid = 1'b0;
    end else if (!s) begin
      m_fdir = fw; m_fdpc = m_pc + 32'd4; m_valid = !flt;
      m_cnt = m_cnt + (flt ? 32'd0 : 32'd1);
      m_fault = m_fault | flt;
    end
    m_pc = b ? bt : j ? jt : s ? m_pc : m_pc + 32'd4;
    e.pc = m_pc; e.fdpc = m_fdpc; e.fdir = m_fdir; e.cnt = m_cnt; e.valid = m_valid; e.fault = m_fault;
    q.push_back(e);
    @(posedge clk);
    #1;
    o = q.pop_front();
    chk("pc", PC, o.pc);
    chk("fd_pc", FD_PC, o.fdpc);
    chk("fd_ir", FD_IR, o.fdir);
    chk("fd_valid", {31'd0, fd_valid}, {31'd0, o.valid});
    chk("imem_fault", {31'd0, imem_fault}, {31'd0, o.fault});
    chk("fetch_count", fetch_count, o.cnt);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h2000_0000 + 32'(i) * 32'h0001_0003;
    mem[0] = 32'h0022_1820;
    mem[1] = NOP;
    for (int i = 0; i < 128; i++) dut.instruction[i] = mem[i];
    model_reset();
    #10;
    chk("rst_pc", PC, 32'd0);
    chk("rst_fd_ir", FD_IR, NOP);
    chk("rst_fd_pc", FD_PC, 32'd0);
    chk("rst_valid", {31'd0, fd_valid}, 32'd0);
    chk("rst_fault", {31'd0, imem_fault}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    #2 rst = 1'b0;
    run(1);
    chk("seq_first_ir", FD_IR, 32'h0022_1820);
    chk("seq_first_fdpc", FD_PC, 32'd4);
    run(1);
    chk("seq_pc8", PC, 32'd8);
    chk("seq_count2", fetch_count, 32'd2);
    run(3);
    chk("seq_pc20", PC, 32'd20);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("stall_pc", PC, 32'd20);
    chk("stall_count", fetch_count, 32'd5);
    run(1);
    chk("unstall_ir", FD_IR, mem[5]);
    chk("unstall_fdpc", FD_PC, 32'd24);
    step(1'b0, 1'b1, 1'b1, 32'd60, 1'b0, 32'd0);
    chk("br_pc", PC, 32'd60);
    chk("br_bubble", FD_IR, NOP);
    run(1);
    chk("br_target_ir", FD_IR, mem[15]);
    chk("br_target_fdpc", FD_PC, 32'd64);
    step(1'b1, 1'b0, 1'b1, 32'd100, 1'b1, 32'd40);
    chk("prio_pc", PC, 32'd100);
    chk("prio_hold_fdpc", FD_PC, 32'd64);
    run(1);
    chk("after_br_ir", FD_IR, mem[25]);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd512);
    chk("delay_slot_ir", FD_IR, mem[26]);
    run(1);
    chk("oor_fault", {31'd0, imem_fault}, 32'd1);
    chk("oor_ir", FD_IR, NOP);
    chk("oor_pc", PC, 32'd516);
    run(1);
    chk("oor_pc2", PC, 32'd520);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd28);
    chk("fault_sticky", {31'd0, imem_fault}, 32'd1);
    run(2);
    chk("pre_rst_pc", PC, 32'd36);
    #2 rst = 1'b1;
    #1;
    chk("arst_pc", PC, 32'd0);
    chk("arst_fd_ir", FD_IR, NOP);
    chk("arst_count", fetch_count, 32'd0);
    chk("arst_fault", {31'd0, imem_fault}, 32'd0);
    chk("arst_valid", {31'd0, fd_valid}, 32'd0);
    model_reset();
    #3 rst = 1'b0;
    run(2);
    chk("post_rst_ir", FD_IR, mem[1]);
    chk("post_rst_count", fetch_count, 32'd2);
    step(1'b0, 1'b0, 1'b1, 32'd42, 1'b0, 32'd0);
    run(1);
    chk("unaligned_fault", {31'd0, imem_fault}, 32'd1);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
